// File: rtl/knn_local_buf_banked_1r1w.sv
// Banked simple-dual-port local buffer for partial-KNN kernels: one byte-masked write port,
// one pipelined read port with write-first merge, and a row-sweeping clear engine.
module knn_local_buf_banked_1r1w #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int AddressRange = 2048,
  parameter int NumBanks     = 2,
  parameter int ReadLatency  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_start,
  output logic                      clear_busy,
  input  logic                      wr_en,
  input  logic [AddressWidth-1:0]   wr_addr,
  input  logic [DataWidth/8-1:0]    wr_be,
  input  logic [DataWidth-1:0]      wr_data,
  input  logic                      rd_en,
  input  logic [AddressWidth-1:0]   rd_addr,
  output logic                      rd_valid,
  output logic [DataWidth-1:0]      rd_data,
  output logic                      rd_collision
);

  localparam int NumBytes  = DataWidth / 8;
  localparam int NumRows   = AddressRange / NumBanks;
  localparam int BankShift = $clog2(NumBanks);
  localparam int BankBits  = (NumBanks > 1) ? BankShift : 1;
  localparam int RowBits   = (NumRows > 1) ? $clog2(NumRows) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic [BankBits-1:0] bank_of(input logic [AddressWidth-1:0] a);
    return BankBits'(a & AddressWidth'(NumBanks - 1));
  endfunction

  function automatic logic [RowBits-1:0] row_of(input logic [AddressWidth-1:0] a);
    return RowBits'(a >> BankShift);
  endfunction

  function automatic logic in_range(input logic [AddressWidth-1:0] a);
    return {1'b0, a} < (AddressWidth + 1)'(AddressRange);
  endfunction

  state_t             state, state_next;
  logic [RowBits-1:0] clear_row;
  logic               clear_last;

  assign clear_last = (clear_row == RowBits'(NumRows - 1));
  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clear_row <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clear_row <= clear_last ? '0 : clear_row + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (clear_start) state_next = CLEAR;
      CLEAR: if (clear_last)  state_next = IDLE;
    endcase
  end

  logic               wr_accept, rd_accept, rd_ok, collision;
  logic [BankBits-1:0] wr_bank, rd_bank;
  logic [RowBits-1:0]  wr_row, rd_row;

  assign wr_bank   = bank_of(wr_addr);
  assign wr_row    = row_of(wr_addr);
  assign rd_bank   = bank_of(rd_addr);
  assign rd_row    = row_of(rd_addr);
  assign wr_accept = (state == IDLE) && wr_en && in_range(wr_addr);
  assign rd_accept = (state == IDLE) && rd_en;
  assign rd_ok     = in_range(rd_addr);
  assign collision = wr_accept && rd_accept && rd_ok && (wr_addr == rd_addr);

  logic [DataWidth-1:0] mem [NumBanks][NumRows];

  // NOTE: the storage array has no reset; only control and pipeline state are cleared by reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int b = 0; b < NumBanks; b++) mem[b][clear_row] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < NumBytes; i++)
        if (wr_be[i]) mem[wr_bank][wr_row][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Write-first view: old word with the same-cycle write's enabled bytes folded in.
  logic [DataWidth-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[rd_bank][rd_row];
      if (collision)
        for (int i = 0; i < NumBytes; i++)
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  logic [ReadLatency-1:0]                pipe_valid, pipe_coll;
  logic [ReadLatency-1:0][DataWidth-1:0] pipe_data;

  // NOTE: sequential state is updated with non-blocking assignments so every stage shifts from the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_coll  <= '0;
      pipe_data  <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_coll[0]  <= collision;
      pipe_data[0]  <= rd_accept ? rd_word : '0;
      for (int s = 1; s < ReadLatency; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_coll[s]  <= pipe_coll[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
    end
  end

  assign rd_valid     = pipe_valid[ReadLatency-1];
  assign rd_collision = pipe_coll[ReadLatency-1];
  assign rd_data      = pipe_data[ReadLatency-1];

endmodule

// File: tb/tb_knn_local_buf_banked_1r1w.sv
// Scoreboard bench: drivers push expected read responses with their due cycle; per-DUT monitors
// pop and compare on every rd_valid. A second instance covers a non-power-of-two AddressRange.
module tb_knn_local_buf_banked_1r1w;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int BW = DW / 8;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          clear_start, clear_busy, wr_en, rd_en, rd_valid, rd_collision;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [BW-1:0] wr_be;
  logic [DW-1:0] wr_data, rd_data;

  logic          b_clear_start, b_clear_busy, b_wr_en, b_rd_en, b_rd_valid, b_rd_collision;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [BW-1:0] b_wr_be;
  logic [DW-1:0] b_wr_data, b_rd_data;

  knn_local_buf_banked_1r1w #(
    .DataWidth(DW), .AddressWidth(AW), .AddressRange(2048), .NumBanks(2), .ReadLatency(L)
  ) dut (
    .clk(clk), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_collision(rd_collision)
  );

  knn_local_buf_banked_1r1w #(
    .DataWidth(DW), .AddressWidth(AW), .AddressRange(2000), .NumBanks(2), .ReadLatency(L)
  ) dut2 (
    .clk(clk), .reset(reset), .clear_start(b_clear_start), .clear_busy(b_clear_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .rd_collision(b_rd_collision)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          coll;
    string         tag;
  } exp_t;

  exp_t          q1[$], q2[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] model [2048];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {8{w}};
  endfunction

  // Monitor for the full-range instance.
  exp_t e1;
  always @(negedge clk) begin
    if (!reset) begin
      while (q1.size() > 0 && q1[0].due < cyc) begin
        e1 = q1.pop_front();
        check({"missing rd_valid ", e1.tag}, DW'(0), DW'(1));
      end
      if (rd_valid) begin
        if (q1.size() == 0) check("unexpected rd_valid", DW'(rd_valid), DW'(0));
        else begin
          e1 = q1.pop_front();
          check({"latency ", e1.tag}, DW'(cyc), DW'(e1.due));
          check({"rd_data ", e1.tag}, rd_data, e1.data);
          check({"rd_collision ", e1.tag}, DW'(rd_collision), DW'(e1.coll));
        end
      end else check("rd_data idle", rd_data, '0);
    end
  end

  // Monitor for the AddressRange=2000 instance.
  exp_t e2;
  always @(negedge clk) begin
    if (!reset) begin
      while (q2.size() > 0 && q2[0].due < cyc) begin
        e2 = q2.pop_front();
        check({"missing rd_valid ", e2.tag}, DW'(0), DW'(1));
      end
      if (b_rd_valid) begin
        if (q2.size() == 0) check("unexpected rd_valid dut2", DW'(b_rd_valid), DW'(0));
        else begin
          e2 = q2.pop_front();
          check({"latency ", e2.tag}, DW'(cyc), DW'(e2.due));
          check({"rd_data ", e2.tag}, b_rd_data, e2.data);
          check({"rd_collision ", e2.tag}, DW'(b_rd_collision), DW'(e2.coll));
        end
      end
    end
  end

  // One cycle on the full-range instance; hand=1 pushes the given expectation instead of the model's.
  task automatic cyc1(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic hand, input logic [DW-1:0] hd, input logic hc, input string tag);
    exp_t          e;
    logic [DW-1:0] d;
    @(negedge clk);
    clear_start = 1'b0;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re) begin
      d = model[ra];
      e.coll = 1'b0;
      if (we && wa == ra) begin
        e.coll = 1'b1;
        for (int i = 0; i < BW; i++) if (be[i]) d[8*i +: 8] = wd[8*i +: 8];
      end
      e.data = d;
      if (hand) begin
        e.data = hd;
        e.coll = hc;
      end
      e.due = cyc + L;
      e.tag = tag;
      q1.push_back(e);
    end
    if (we) for (int i = 0; i < BW; i++) if (be[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
  endtask

  task automatic cyc2(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra,
                      input logic [DW-1:0] hd, input logic hc, input string tag);
    exp_t e;
    @(negedge clk);
    b_wr_en = we; b_wr_addr = wa; b_wr_be = '1; b_wr_data = wd;
    b_rd_en = re; b_rd_addr = ra;
    if (re) begin
      e.data = hd;
      e.coll = hc;
      e.due  = cyc + L;
      e.tag  = tag;
      q2.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      b_wr_en = 1'b0; b_rd_en = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  int cnt;

  initial begin
    reset = 1'b1;
    clear_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    b_clear_start = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_addr = '0; b_rd_addr = '0; b_wr_be = '0; b_wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset rd_valid", DW'(rd_valid), '0);
    check("reset rd_data", rd_data, '0);
    check("reset rd_collision", DW'(rd_collision), '0);
    check("reset clear_busy", DW'(clear_busy), '0);
    check("reset clear_busy dut2", DW'(b_clear_busy), '0);
    reset = 1'b0;

    // Write then read the next cycle.
    cyc1(1, 11'd5, '1, {32{8'hA5}}, 0, 11'd0, 0, '0, 0, "");
    cyc1(0, 11'd0, '0, '0, 1, 11'd5, 1, {32{8'hA5}}, 0, "rd5 after write");

    // Same-cycle write/read to one address: byte-merged, collision flagged.
    cyc1(1, 11'd7, '1, {32{8'h11}}, 0, 11'd0, 0, '0, 0, "");
    cyc1(1, 11'd7, 32'h0000_000F, {32{8'hFF}}, 1, 11'd7, 1, {{28{8'h11}}, {4{8'hFF}}}, 1, "collision merge");
    cyc1(0, 11'd0, '0, '0, 1, 11'd7, 1, {{28{8'h11}}, {4{8'hFF}}}, 0, "rd7 after merge");

    // A write one cycle after a read's issue must not leak into it.
    cyc1(0, 11'd0, '0, '0, 1, 11'd5, 1, {32{8'hA5}}, 0, "rd5 before overwrite");
    cyc1(1, 11'd5, '1, {32{8'h3C}}, 0, 11'd0, 0, '0, 0, "");
    cyc1(0, 11'd0, '0, '0, 1, 11'd5, 1, {32{8'h3C}}, 0, "rd5 after overwrite");

    // All-zero byte enables leave the word untouched.
    cyc1(1, 11'd5, '0, '1, 0, 11'd0, 0, '0, 0, "");
    cyc1(0, 11'd0, '0, '0, 1, 11'd5, 1, {32{8'h3C}}, 0, "be zero no change");

    // Back-to-back stream over both banks with concurrent writes elsewhere.
    for (int i = 0; i < 64; i++) cyc1(1, AW'(i), '1, pat(i), 0, 11'd0, 0, '0, 0, "");
    for (int i = 0; i < 64; i++) cyc1(1, AW'(64 + i), '1, pat(64 + i), 1, AW'(i), 0, '0, 0, "stream");
    idle(4);

    // Fill everything, clear, and confirm traffic during the sweep is dropped.
    for (int a = 0; a < 2048; a++) cyc1(1, AW'(a), '1, ~pat(a), 0, 11'd0, 0, '0, 0, "");
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b1;
    cnt = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      clear_start = (k == 10);
      if (!clear_busy) break;
      cnt++;
      wr_en = 1'b1; wr_addr = AW'(k); wr_be = '1; wr_data = '1;
      rd_en = 1'b1; rd_addr = AW'(k);
    end
    wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
    check("clear_busy cycles", DW'(cnt), DW'(1024));
    for (int a = 0; a < 2048; a++) model[a] = '0;
    for (int a = 0; a < 2048; a++) cyc1(0, 11'd0, '0, '0, 1, AW'(a), 0, '0, 0, "after clear");
    idle(4);

    // Reset during the sweep, just after row 99 has been zeroed.
    for (int a = 180; a < 220; a++) cyc1(1, AW'(a), '1, pat(a + 7), 0, 11'd0, 0, '0, 0, "");
    idle(3);
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (100) @(negedge clk);
    check("clear_busy before reset", DW'(clear_busy), DW'(1));
    reset = 1'b1;
    #1;
    check("clear_busy async drop", DW'(clear_busy), '0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 200; a++) model[a] = '0;
    for (int a = 190; a < 220; a++) cyc1(0, 11'd0, '0, '0, 1, AW'(a), 0, '0, 0, "partial clear");
    idle(4);

    // Out-of-range handling with AddressRange=2000.
    cyc2(1, 11'd1999, {32{8'h77}}, 0, 11'd0, '0, 0, "");
    cyc2(1, 11'd2047, '1, 1, 11'd1999, {32{8'h77}}, 0, "dut2 last in range");
    cyc2(1, 11'd2047, '1, 1, 11'd2047, '0, 0, "dut2 oor same-cycle");
    cyc2(0, 11'd0, '0, 1, 11'd2047, '0, 0, "dut2 oor read");
    cyc2(0, 11'd0, '0, 1, 11'd1999, {32{8'h77}}, 0, "dut2 1999 unaffected");
    idle(6);

    check("dut1 queue drained", DW'(q1.size()), '0);
    check("dut2 queue drained", DW'(q2.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_local_buf_banked_1r1w.md
# knn_local_buf_banked_1r1w

Parametrised, banked, simple-dual-port local buffer for partial-KNN kernels, successor to the single-port URAM local-store wrapper. It provides one write port and one independent, fully pipelined read port, with per-byte write enables and a configurable read latency (URAM output-register stages). It also has a hardware clear engine that zeroes the whole buffer between query batches. It sits between the distance-compute pipeline (writer) and the top-K sort stage (reader).

## Interface
- DataWidth, 256: word width in bits, multiple of 8.
- AddressWidth, 11: word address width.
- AddressRange, 2048: number of words, ≤ 2^AddressWidth, multiple of NumBanks.
- NumBanks, 2: power of 2, ≥1; bank = addr[log2(NumBanks)-1:0], row = addr >> log2(NumBanks).
- ReadLatency, 2: 1..4, cycles from rd_en to rd_valid.
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- clear_start  in  1  pulse: begin zeroing all words.
- clear_busy  out  1  high while clear engine runs.
- wr_en  in  1  write request.
- wr_addr  in  AddressWidth  write word address.
- wr_be  in  DataWidth/8  byte enables, bit i covers d[8i+7:8i].
- wr_data  in  DataWidth  write data.
- rd_en  in  1  read request.
- rd_addr  in  AddressWidth  read word address.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  DataWidth  read data, zero when rd_valid low.
- rd_collision  out  1  aligned with rd_valid: the read hit a same-cycle write to the same address.

## Operation
- Reset: rd_valid=0, rd_data=0, rd_collision=0, clear_busy=0, FSM→IDLE, all pipeline stages invalidated. Array contents are not reset.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on clear_start.
  - CLEAR writes zero to row r of every bank each cycle, r = 0..AddressRange/NumBanks-1.
  - CLEAR→IDLE after the last row is written.
  - clear_start while in CLEAR is ignored.
- During CLEAR: wr_en and rd_en are dropped (no array update, no rd_valid). Reads already in the pipeline complete normally.
- Write (IDLE, wr_en, wr_addr < AddressRange): bytes with wr_be=1 are updated at the clock edge; other bytes are unchanged. wr_be=0 means no change.
- Read (IDLE, rd_en): issued to the selected bank; result is delivered ReadLatency cycles later.
- Same-cycle read and write to the same address: write-first, byte-merged. The returned bytes are new data where wr_be=1 and old data elsewhere; rd_collision=1 with that result.
- Writes issued after a read's issue cycle never affect that read's data.
- Out-of-range addresses (≥ AddressRange): write dropped; read returns rd_valid=1, rd_data=0, rd_collision=0.
- Reset mid-clear abandons the clear. clear_busy drops immediately (asynchronous), and partially cleared contents remain.

## Timing
- Read latency exactly ReadLatency cycles: rd_en sampled at edge T → rd_valid/rd_data/rd_collision asserted in cycle T+ReadLatency for one cycle.
- Throughput: one read and one write per cycle, back-to-back, no bubbles, bank conflicts impossible (one access per port per cycle).
- Write visible to a read issued at the next edge (T+1). Same-edge visibility is via the merge rule.
- clear_busy rises the cycle after clear_start is sampled and stays high exactly AddressRange/NumBanks cycles.
- rd_data is registered at the final pipeline stage; no combinational path from inputs to outputs.

## Test plan
- Reset, then write 0xA5 pattern to addr 5 (all be), read addr 5 at next cycle → rd_valid exactly ReadLatency=2 cycles later, rd_data=0xA5…A5, rd_collision=0.
- Preload addr 7 = all 0x11; same cycle write addr 7 data all 0xFF with wr_be=0x0000_000F and read addr 7 → rd_data low 4 bytes 0xFF, rest 0x11, rd_collision=1.
- Stream rd_en every cycle over addr 0..63 alternating banks (NumBanks=2) → 64 consecutive rd_valid cycles, data in order, no gaps.
- Fill memory, pulse clear_start → clear_busy high 1024 cycles (defaults); wr/rd during busy dropped; afterwards every address reads 0.
- Assert reset during CLEAR at row 100 → clear_busy=0 at once; rows ≥100 keep old data, rows <100 read 0.
- Read addr 2047 with AddressRange=2000 (non-default) → rd_valid=1, rd_data=0; write to it has no effect.
